// File: rtl/sample_link_codec.sv
// sample_link_codec: full-duplex N-channel sample framer for a byte FIFO link.
// TX packs each W-bit channel into K = ceil(W/7) 7-bit groups (MSB group first),
// the first byte of a frame carrying bit7 = 1 as the marker. RX hunts for the
// marker, collects L = N*K bytes and publishes the decoded set for one cycle.
// Optional feature: define SAMPLE_LINK_CHECKSUM_EN to append a 7-bit sum byte
// to every frame and verify it on receive.
module sample_link_codec #(
   parameter int W        = 14,
   parameter int N        = 2,
   parameter int LED_HOLD = 7200000
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N*W-1:0]   adc_data_i,
   input  logic             adc_valid_i,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   input  logic             tx_err_i,
   input  logic [7:0]       rx_data_i,
   input  logic             rx_valid_i,
   output logic [N*W-1:0]   dac_data_o,
   output logic             dac_valid_o,
   output logic             led_txerr_o,
   output logic             led_rxerr_o
);

   localparam int K = (W + 6) / 7;
   localparam int L = N * K;
`ifdef SAMPLE_LINK_CHECKSUM_EN
   localparam int FL = L + 1;
`else
   localparam int FL = L;
`endif
   localparam int IW = (FL > 1) ? $clog2(FL) : 1;
   localparam int CW = $clog2(LED_HOLD + 1);

   localparam logic TX_IDLE    = 1'b0;
   localparam logic TX_SEND    = 1'b1;
   localparam logic RX_HUNT    = 1'b0;
   localparam logic RX_COLLECT = 1'b1;

   // ------------------------------------------------------------------ TX
   logic           tx_state;
   logic [IW-1:0]  tx_idx;
   logic [N*W-1:0] tx_buf;
   logic [6:0]     tx_grp [L];
   logic           tx_last;
   logic           tx_event;
`ifdef SAMPLE_LINK_CHECKSUM_EN
   logic [6:0]     tx_sum;
`endif

   // Split the captured set into 7-bit payload groups in frame order
   always_comb begin
      for (int i = 0; i < L; i++) begin
         tx_grp[i] = '0;
      end
      for (int c = 0; c < N; c++) begin
         for (int b = 0; b < W; b++) begin
            tx_grp[c*K + K - 1 - b/7][b%7] = tx_buf[c*W + b];
         end
      end
`ifdef SAMPLE_LINK_CHECKSUM_EN
      tx_sum = '0;
      for (int i = 0; i < L; i++) begin
         tx_sum = tx_sum + tx_grp[i];
      end
`endif
   end

   // Select the byte at the current frame index; zero whenever nothing is offered
   always_comb begin
      tx_data_o = '0;
      if (tx_state == TX_SEND) begin
         for (int i = 0; i < L; i++) begin
            if (tx_idx == IW'(i)) begin
               tx_data_o = {(i == 0), tx_grp[i]};
            end
         end
`ifdef SAMPLE_LINK_CHECKSUM_EN
         if (tx_idx == IW'(L)) begin
            tx_data_o = {1'b0, tx_sum};
         end
`endif
      end
   end

   assign tx_valid_o = (tx_state == TX_SEND);
   assign tx_last    = (tx_idx == IW'(FL - 1));
   // A strobe is dropped unless it lands on the final accepted byte; a link error aborts
   assign tx_event   = (tx_state == TX_SEND) &
                       (tx_err_i | (adc_valid_i & ~(tx_ready_i & tx_last)));

   // TX sequencer: capture a set, walk the frame, chain a new set on the last byte
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_state <= TX_IDLE;
         tx_idx   <= '0;
         tx_buf   <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (adc_valid_i) begin
                  tx_buf   <= adc_data_i;
                  tx_idx   <= '0;
                  tx_state <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (tx_err_i) begin
                  tx_idx   <= '0;
                  tx_state <= TX_IDLE;
               end else if (tx_ready_i) begin
                  if (tx_last) begin
                     tx_idx <= '0;
                     if (adc_valid_i) begin
                        tx_buf <= adc_data_i;
                     end else begin
                        tx_state <= TX_IDLE;
                     end
                  end else begin
                     tx_idx <= tx_idx + IW'(1);
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ RX
   logic           rx_state;
   logic [IW-1:0]  rx_cnt;
   logic [6:0]     rx_grp   [FL];
   logic [6:0]     rx_frame [FL];
   logic [IW-1:0]  rx_slot;
   logic           rx_marker;
   logic           rx_done;
   logic           rx_ok;
   logic           rx_event;
   logic [N*W-1:0] rx_dec;

   assign rx_marker = rx_data_i[7];
   // A marker always restarts at slot 0, even mid-frame
   assign rx_slot   = (rx_state == RX_HUNT || rx_marker) ? '0 : rx_cnt;
   assign rx_done   = rx_valid_i & (rx_marker ? (FL == 1)
                                              : (rx_state == RX_COLLECT &&
                                                 rx_cnt == IW'(FL - 1)));

   // Assemble the complete frame including the byte arriving this cycle, then decode it
   always_comb begin
      for (int i = 0; i < FL; i++) begin
         rx_frame[i] = (rx_slot == IW'(i)) ? rx_data_i[6:0] : rx_grp[i];
      end
      rx_dec = '0;
      for (int c = 0; c < N; c++) begin
         for (int b = 0; b < W; b++) begin
            rx_dec[c*W + b] = rx_frame[c*K + K - 1 - b/7][b%7];
         end
      end
`ifdef SAMPLE_LINK_CHECKSUM_EN
      begin
         logic [6:0] sum;
         sum = '0;
         for (int i = 0; i < L; i++) begin
            sum = sum + rx_frame[i];
         end
         rx_ok = (sum == rx_frame[L]);
      end
`else
      rx_ok = 1'b1;
`endif
   end

   assign rx_event = rx_valid_i & (((rx_state == RX_HUNT) & ~rx_marker) |
                                   ((rx_state == RX_COLLECT) & rx_marker) |
                                   (rx_done & ~rx_ok));

   // Frame buffer: store each payload into its slot; stale slots are always overwritten
   always_ff @(posedge clk_i) begin
      if (rx_valid_i) begin
         for (int i = 0; i < FL; i++) begin
            if (rx_slot == IW'(i)) begin
               rx_grp[i] <= rx_data_i[6:0];
            end
         end
      end
   end

   // RX sequencer: hunt for a marker, count bytes, publish good frames for one cycle
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rx_state    <= RX_HUNT;
         rx_cnt      <= '0;
         dac_data_o  <= '0;
         dac_valid_o <= 1'b0;
      end else begin
         dac_valid_o <= 1'b0;
         if (rx_valid_i) begin
            if (rx_done) begin
               rx_state <= RX_HUNT;
               rx_cnt   <= '0;
               if (rx_ok) begin
                  dac_data_o  <= rx_dec;
                  dac_valid_o <= 1'b1;
               end
            end else if (rx_marker) begin
               rx_state <= RX_COLLECT;
               rx_cnt   <= IW'(1);
            end else if (rx_state == RX_COLLECT) begin
               rx_cnt <= rx_cnt + IW'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------ LEDs
   logic [CW-1:0] tx_led_cnt;
   logic [CW-1:0] rx_led_cnt;

   // Error stretchers: reload on an event, otherwise count down to zero
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_led_cnt <= '0;
         rx_led_cnt <= '0;
      end else begin
         if (tx_event) begin
            tx_led_cnt <= CW'(LED_HOLD);
         end else if (tx_led_cnt != '0) begin
            tx_led_cnt <= tx_led_cnt - CW'(1);
         end
         if (rx_event) begin
            rx_led_cnt <= CW'(LED_HOLD);
         end else if (rx_led_cnt != '0) begin
            rx_led_cnt <= rx_led_cnt - CW'(1);
         end
      end
   end

   assign led_txerr_o = (tx_led_cnt != '0);
   assign led_rxerr_o = (rx_led_cnt != '0);

endmodule
